// File: rtl/padd_stream.sv
// Streaming projective point adder R = P + Q over Montgomery-form coordinates.
// Fixed-latency pipeline, tag sideband, infinity bypass, P==Q flag, credit-guarded output FIFO.

module padd_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// N parallel Montgomery multipliers sharing one modulus: p = a*b*2^-(W*L) mod q.
// Latency ID + 2*L + 1; q must satisfy q == 1 mod 2^W so each digit factor is just -T mod 2^W.
module padd_mul_bank #(
    parameter int DW = 30,
    parameter int W  = 12,
    parameter int L  = 3,
    parameter int ID = 3,
    parameter int N  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*DW-1:0] a,
    input  logic [N*DW-1:0] b,
    input  logic [DW-1:0]   q,
    output logic [N*DW-1:0] p,
    output logic [DW-1:0]   q_out
);
    localparam int PW = 2*DW + W + 1;
    localparam int D  = ID + 2*L + 1;

    logic [DW-1:0] q_sr [D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) q_sr[i] <= '0;
        end else begin
            q_sr[0] <= q;
            for (int i = 1; i < D; i++) q_sr[i] <= q_sr[i-1];
        end
    end

    assign q_out = q_sr[D-1];

    for (genvar n = 0; n < N; n++) begin : g_lane
        logic [PW-1:0] prod  [ID];
        logic [PW-1:0] src   [L];
        logic [PW-1:0] hold  [L];
        logic [PW-1:0] t_out [L];
        logic [W-1:0]  m     [L];
        logic [PW-1:0] fin;
        logic [DW-1:0] res;

        always_comb begin
            src[0] = prod[ID-1];
            for (int j = 1; j < L; j++) src[j] = t_out[j-1];
        end

        assign fin = t_out[L-1];

        // each digit step: register T and m, then (T + m*q) >> W using that transaction's q
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < ID; k++) prod[k] <= '0;
                for (int j = 0; j < L; j++) begin
                    hold[j]  <= '0;
                    m[j]     <= '0;
                    t_out[j] <= '0;
                end
                res <= '0;
            end else begin
                prod[0] <= PW'(a[n*DW +: DW]) * PW'(b[n*DW +: DW]);
                for (int k = 1; k < ID; k++) prod[k] <= prod[k-1];
                for (int j = 0; j < L; j++) begin
                    hold[j]  <= src[j];
                    m[j]     <= ~src[j][W-1:0] + W'(1);
                    t_out[j] <= (hold[j] + PW'(m[j]) * PW'(q_sr[ID + 2*j])) >> W;
                end
                res <= (fin >= PW'(q_sr[D-2])) ? DW'(fin - PW'(q_sr[D-2])) : DW'(fin);
            end
        end

        assign p[n*DW +: DW] = res;
    end
endmodule

module padd_stream #(
    parameter int DATA_WIDTH   = 30,
    parameter int RING_LENGTH  = 2048,
    parameter int INTMUL_DELAY = 3,
    parameter int TAG_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         x_p,
    input  logic [DATA_WIDTH-1:0]         y_p,
    input  logic [DATA_WIDTH-1:0]         z_p,
    input  logic [DATA_WIDTH-1:0]         x_q,
    input  logic [DATA_WIDTH-1:0]         y_q,
    input  logic [DATA_WIDTH-1:0]         z_q,
    input  logic [DATA_WIDTH-1:0]         mod,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         x_r,
    output logic [DATA_WIDTH-1:0]         y_r,
    output logic [DATA_WIDTH-1:0]         z_r,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic                          out_dbl,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
    localparam int DW      = DATA_WIDTH;
    localparam int TW      = TAG_WIDTH;
    localparam int W_SIZE  = $clog2(RING_LENGTH) + 1;
    localparam int L_RAW   = (DW + W_SIZE - 1) / W_SIZE;
    localparam int L_SIZE  = (L_RAW < 1) ? 1 : ((L_RAW > 8) ? 8 : L_RAW);
    localparam int MUL_LAT = INTMUL_DELAY + 2*L_SIZE + 1;
    localparam int LAT     = 4*MUL_LAT + 2;
    localparam int OW      = $clog2(FIFO_DEPTH) + 1;
    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SBW     = 2 + TW + 3*DW;
    localparam int RW      = 1 + TW + 3*DW;

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] q);
        return (a < b) ? (a - b + q) : (a - b);
    endfunction

    logic          live, accept, push, pop, s0_v;
    logic [OW-1:0] credits, occ;
    logic [DW-1:0] s0_xp, s0_yp, s0_zp, s0_xq, s0_yq, s0_zq, s0_q;
    logic [TW-1:0] s0_tag;

    assign in_ready = live && (credits < OW'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live  <= 1'b0;
            s0_v  <= 1'b0;
            s0_xp <= '0; s0_yp <= '0; s0_zp <= '0;
            s0_xq <= '0; s0_yq <= '0; s0_zq <= '0;
            s0_q  <= '0; s0_tag <= '0;
        end else begin
            live <= 1'b1;
            s0_v <= accept;
            if (accept) begin
                s0_xp <= x_p; s0_yp <= y_p; s0_zp <= z_p;
                s0_xq <= x_q; s0_yq <= y_q; s0_zq <= z_q;
                s0_q  <= mod; s0_tag <= in_tag;
            end
        end
    end

    logic          byp;
    logic [DW-1:0] bx, by, bz;

    always_comb begin
        byp = (s0_zp == '0) || (s0_zq == '0);
        bx  = s0_xq;
        by  = s0_yq;
        bz  = s0_zq;
        if (s0_zp == '0 && s0_zq == '0) begin
            bx = '0;
            by = DW'(1);
            bz = '0;
        end else if (s0_zq == '0) begin
            bx = s0_xp;
            by = s0_yp;
            bz = s0_zp;
        end
    end

    logic [SBW-1:0] sb_q;
    logic           e_v, e_byp, e_dbl;
    logic [TW-1:0]  e_tag;
    logic [DW-1:0]  e_bx, e_by, e_bz;

    padd_delay #(.WIDTH(SBW), .DEPTH(LAT-1)) u_sb (
        .clk(clk), .rst_n(rst_n), .d({s0_v, byp, s0_tag, bx, by, bz}), .q(sb_q));
    assign {e_v, e_byp, e_tag, e_bx, e_by, e_bz} = sb_q;

    // S1: cross products, then U, V
    logic [5*DW-1:0] p1;
    logic [DW-1:0]   u1_m, u2_m, v1_m, v2_m, w_m, q1_m;
    logic [DW-1:0]   u_1, v_1, u2_1, v2_1, w_1, q_1;

    padd_mul_bank #(.DW(DW), .W(W_SIZE), .L(L_SIZE), .ID(INTMUL_DELAY), .N(5)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .a({s0_zp, s0_xp, s0_xq, s0_yp, s0_yq}),
        .b({s0_zq, s0_zq, s0_zp, s0_zq, s0_zp}),
        .q(s0_q), .p(p1), .q_out(q1_m));
    assign {w_m, v2_m, v1_m, u2_m, u1_m} = p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_1 <= '0; v_1 <= '0; u2_1 <= '0; v2_1 <= '0; w_1 <= '0; q_1 <= '0;
        end else begin
            u_1  <= mod_sub(u1_m, u2_m, q1_m);
            v_1  <= mod_sub(v1_m, v2_m, q1_m);
            u2_1 <= u2_m;
            v2_1 <= v2_m;
            w_1  <= w_m;
            q_1  <= q1_m;
        end
    end

    padd_delay #(.WIDTH(1), .DEPTH(3*MUL_LAT)) u_dbl (
        .clk(clk), .rst_n(rst_n), .d(u_1 == '0 && v_1 == '0), .q(e_dbl));

    // S2: squares
    logic [2*DW-1:0] p2;
    logic [DW-1:0]   uu, vv, q_2, u_2, v_2, u2_2, v2_2, w_2;

    padd_mul_bank #(.DW(DW), .W(W_SIZE), .L(L_SIZE), .ID(INTMUL_DELAY), .N(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .a({v_1, u_1}), .b({v_1, u_1}),
        .q(q_1), .p(p2), .q_out(q_2));
    assign {vv, uu} = p2;

    padd_delay #(.WIDTH(5*DW), .DEPTH(MUL_LAT)) u_d2 (
        .clk(clk), .rst_n(rst_n), .d({u_1, v_1, u2_1, v2_1, w_1}),
        .q({u_2, v_2, u2_2, v2_2, w_2}));

    // S3: A1, A2, A3
    logic [3*DW-1:0] p3;
    logic [DW-1:0]   a1, a2, a3, q_3, u_3, v_3, u2_3, w_3, a_t, a3ma;

    padd_mul_bank #(.DW(DW), .W(W_SIZE), .L(L_SIZE), .ID(INTMUL_DELAY), .N(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .a({vv, vv, uu}), .b({v2_2, v_2, w_2}),
        .q(q_2), .p(p3), .q_out(q_3));
    assign {a3, a2, a1} = p3;

    padd_delay #(.WIDTH(4*DW), .DEPTH(MUL_LAT)) u_d3 (
        .clk(clk), .rst_n(rst_n), .d({u_2, v_2, u2_2, w_2}), .q({u_3, v_3, u2_3, w_3}));

    assign a_t  = mod_sub(mod_sub(mod_sub(a1, a2, q_3), a3, q_3), a3, q_3);
    assign a3ma = mod_sub(a3, a_t, q_3);

    // S4: X, Z and the two halves of Y
    logic [4*DW-1:0] p4;
    logic [DW-1:0]   x4, z4, y1, y2, q_4, y4;

    padd_mul_bank #(.DW(DW), .W(W_SIZE), .L(L_SIZE), .ID(INTMUL_DELAY), .N(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .a({a2, u_3, a2, v_3}), .b({u2_3, a3ma, w_3, a_t}),
        .q(q_3), .p(p4), .q_out(q_4));
    assign {y2, y1, z4, x4} = p4;
    assign y4 = mod_sub(y1, y2, q_4);

    // output FIFO; credits guarantee a free slot for every in-flight result
    logic [RW-1:0] mem [FIFO_DEPTH];
    logic [RW-1:0] wdata;
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign push      = e_v;
    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign wdata     = e_byp ? {1'b0, e_tag, e_bx, e_by, e_bz} : {e_dbl, e_tag, x4, y4, z4};
    assign occupancy = occ;
    assign {out_dbl, out_tag, x_r, y_r, z_r} = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            credits <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            occ     <= occ + OW'(push) - OW'(pop);
            credits <= credits + OW'(accept) - OW'(pop);
        end
    end
endmodule

// File: tb/tb_padd_stream.sv
// Randomized scoreboard bench for padd_stream: a modular-arithmetic reference model
// predicts each result at accept time, a negedge monitor checks them in order.

module tb_padd_stream;
    localparam int DW    = 30;
    localparam int TW    = 8;
    localparam int RBITS = 36;
    localparam longint unsigned QT = 64'd1073479681;

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] z;
        logic [TW-1:0] tag;
        logic          dbl;
    } res_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_dbl;
    logic [DW-1:0] x_p = '0, y_p = '0, z_p = '0, x_q = '0, y_q = '0, z_q = '0, mod = '0;
    logic [DW-1:0] x_r, y_r, z_r;
    logic [TW-1:0] in_tag = '0, out_tag;
    logic [6:0]    occupancy;

    int   checks = 0, errors = 0, cyc = 0;
    res_t sb_q[$];
    int   pop_cyc[$];

    padd_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_p(x_p), .y_p(y_p), .z_p(z_p), .x_q(x_q), .y_q(y_q), .z_q(z_q),
        .mod(mod), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .x_r(x_r), .y_r(y_r), .z_r(z_r), .out_tag(out_tag), .out_dbl(out_dbl),
        .occupancy(occupancy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // a*b / 2^RBITS mod q, by halving modulo q
    function automatic longint unsigned mm(longint unsigned a, longint unsigned b, longint unsigned q);
        longint unsigned r = (a * b) % q;
        for (int i = 0; i < RBITS; i++) r = r[0] ? (r + q) >> 1 : r >> 1;
        return r;
    endfunction

    function automatic longint unsigned ms(longint unsigned a, longint unsigned b, longint unsigned q);
        return (a + q - b) % q;
    endfunction

    function automatic res_t model(longint unsigned xp, longint unsigned yp, longint unsigned zp,
                                   longint unsigned xq, longint unsigned yq, longint unsigned zq,
                                   longint unsigned q, logic [TW-1:0] tag);
        res_t r;
        longint unsigned u2, v2, w, u, v, uu, vv, a1, a2, a3, a;
        r.tag = tag;
        r.dbl = 1'b0;
        if (zp == 0 && zq == 0) begin
            r.x = '0; r.y = DW'(1); r.z = '0;
        end else if (zp == 0) begin
            r.x = DW'(xq); r.y = DW'(yq); r.z = DW'(zq);
        end else if (zq == 0) begin
            r.x = DW'(xp); r.y = DW'(yp); r.z = DW'(zp);
        end else begin
            u2 = mm(yp, zq, q);
            v2 = mm(xp, zq, q);
            w  = mm(zp, zq, q);
            u  = ms(mm(yq, zp, q), u2, q);
            v  = ms(mm(xq, zp, q), v2, q);
            uu = mm(u, u, q);
            vv = mm(v, v, q);
            a1 = mm(uu, w, q);
            a2 = mm(vv, v, q);
            a3 = mm(vv, v2, q);
            a  = (a1 + 3 * q - a2 - 2 * a3) % q;
            r.x   = DW'(mm(v, a, q));
            r.z   = DW'(mm(a2, w, q));
            r.y   = DW'(ms(mm(u, ms(a3, a, q), q), mm(a2, u2, q), q));
            r.dbl = (u == 0 && v == 0);
        end
        return r;
    endfunction

    // called #1 after a rising edge; the pair is taken at the next edge if in_ready is high
    task automatic drive(input longint unsigned xp, input longint unsigned yp, input longint unsigned zp,
                         input longint unsigned xq, input longint unsigned yq, input longint unsigned zq,
                         input longint unsigned q, input logic [TW-1:0] tag, output bit acc);
        in_valid = 1'b1;
        x_p = DW'(xp); y_p = DW'(yp); z_p = DW'(zp);
        x_q = DW'(xq); y_q = DW'(yq); z_q = DW'(zq);
        mod = DW'(q);  in_tag = tag;
        acc = in_ready;
        if (acc) sb_q.push_back(model(xp, yp, zp, xq, yq, zq, q, tag));
    endtask

    task automatic drive_rand(output bit acc);
        longint unsigned q, xp, yp, zp, xq, yq, zq, lam;
        int sel;
        q  = longint'($urandom_range(1, 262143)) * 4096 + 1;
        xp = longint'($urandom) % q; yp = longint'($urandom) % q; zp = longint'($urandom) % q;
        xq = longint'($urandom) % q; yq = longint'($urandom) % q; zq = longint'($urandom) % q;
        sel = $urandom_range(0, 15);
        if (sel == 0 || sel == 2) zp = 0;
        if (sel == 1 || sel == 2) zq = 0;
        if (sel == 3 || sel == 4) begin
            lam = longint'($urandom_range(1, 1000000)) % q;
            xq = (lam * xp) % q; yq = (lam * yp) % q; zq = (lam * zp) % q;
        end
        drive(xp, yp, zp, xq, yq, zq, q, TW'($urandom), acc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, sb_q.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got tag %0h expected no result", out_tag);
            end else begin
                e = sb_q.pop_front();
                chk("x_r", x_r, e.x);
                chk("y_r", y_r, e.y);
                chk("z_r", z_r, e.z);
                chk("out_tag", out_tag, e.tag);
                chk("out_dbl", out_dbl, e.dbl);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int lat, n_acc, highs;
        logic [DW-1:0] held;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_x_r", x_r, 0);
        chk("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // single pair, latency
        drive(64'h0123_4567, 64'h0234_5678, 64'h00AB_CDEF, 64'h0345_6789, 64'h0056_789A, 64'h1111_1111,
              QT, 8'h5A, acc);
        chk("t1_accept", acc, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("t1_latency", lat, 42);
        drain("t1_drain", 10);

        // infinity bypass cases, back to back
        drive(11, 12, 0, 7, 9, 3, QT, 8'h01, acc);       chk("t2a_accept", acc, 1); tick();
        drive(4, 5, 1, 21, 22, 0, QT, 8'h02, acc);       chk("t2b_accept", acc, 1); tick();
        drive(4, 5, 0, 21, 22, 0, QT, 8'h03, acc);       chk("t2c_accept", acc, 1); tick();
        // same affine point -> doubling flag
        drive(2, 3, 1, 4, 6, 2, QT, 8'h04, acc);         chk("t3_accept", acc, 1); tick();
        in_valid = 1'b0;
        drain("t23_drain", 80);

        // 200 back-to-back random pairs
        pop_cyc.delete();
        for (int i = 0; i < 200; i++) begin
            drive_rand(acc);
            chk("t4_in_ready", acc, 1);
            tick();
        end
        in_valid = 1'b0;
        drain("t4_drain", 100);
        chk("t4_pops", pop_cyc.size(), 200);
        if (pop_cyc.size() == 200) chk("t4_one_per_cycle", pop_cyc[199] - pop_cyc[0], 199);

        // backpressure: credits cap accepts at the FIFO depth
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 150; i++) begin
            drive_rand(acc);
            if (acc) n_acc++;
            tick();
        end
        chk("t5_accepts", n_acc, 64);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_occupancy", occupancy, 64);
        chk("t5_out_valid", out_valid, 1);
        in_valid = 1'b0;
        held = x_r;
        repeat (3) tick();
        chk("t5_hold", x_r, held);
        pop_cyc.delete();
        out_ready = 1'b1;
        drain("t5_drain", 100);
        chk("t5_pops", pop_cyc.size(), 64);
        chk("t5_occ_empty", occupancy, 0);
        chk("t5_in_ready_back", in_ready, 1);

        // reset with 20 pairs in flight
        for (int i = 0; i < 20; i++) begin
            drive_rand(acc);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb_q.delete();
        tick();
        chk("t6_out_valid_rst", out_valid, 0);
        chk("t6_occupancy_rst", occupancy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_in_ready", in_ready, 1);
        chk("t6_occupancy", occupancy, 0);
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) highs++;
            tick();
        end
        chk("t6_no_stale", highs, 0);

        // pipeline still healthy after reset
        drive_rand(acc);
        chk("t7_accept", acc, 1);
        tick();
        in_valid = 1'b0;
        drain("t7_drain", 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
